// File: rtl/mc_control_fsm.sv
// Multicycle control unit: sequences fetch/decode/execute/memory/writeback for one instruction at a time.
// Latency: outputs follow the current state in the same cycle; the state register advances on each rising edge.
// Backpressure: none; the unit never stalls, and a high reset overrides any step in progress.
//
// Ports:
//   clk, reset               rising-edge clock, synchronous active-high reset
//   op, funct3, funct7b5     instruction fields from the instruction register
//   zero                     ALU zero flag, used only while resolving a branch
//   immsrc                   extender select (I/S/B/J), decoded from op every cycle
//   alusrca, alusrcb         ALU operand muxes
//   resultsrc, adrsrc        result mux and memory address mux
//   alucontrol               ALU operation
//   irwrite, pcwrite,
//   regwrite, memwrite       architectural write enables
//   retire                   one pulse in the last cycle of each instruction
//   illegal                  pulse in DECODE when the opcode is not supported
module mc_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic [1:0] immsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic       adrsrc,
  output logic [2:0] alucontrol,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       retire,
  output logic       illegal
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BR   = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_JAL,
    S_BRANCH
  } state_t;

  // Moore control word: everything that depends on the state alone.
  typedef struct packed {
    logic       irwrite;
    logic       pcupdate;
    logic       branch;
    logic       regwrite;
    logic       memwrite;
    logic       retire;
    logic       adrsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic [1:0] aluop;
  } ctl_t;

  state_t state;
  state_t nxt;
  ctl_t   ctl_q;
  ctl_t   ctl;
  logic   supported;
  logic   dec_illegal;
  logic   taken;

  function automatic state_t next_state(input state_t s, input logic [6:0] o);
    state_t n;
    n = S_FETCH;
    case (s)
      S_FETCH:  n = S_DECODE;
      S_DECODE: begin
        case (o)
          OP_LW, OP_SW: n = S_MEMADR;
          OP_R:         n = S_EXECR;
          OP_I:         n = S_EXECI;
          OP_JAL:       n = S_JAL;
          OP_BR:        n = S_BRANCH;
          default:      n = S_FETCH;
        endcase
      end
      S_MEMADR:       n = (o == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:      n = S_MEMWB;
      S_EXECR,
      S_EXECI:        n = S_ALUWB;
      default:        n = S_FETCH;
    endcase
    return n;
  endfunction

  function automatic ctl_t moore(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.irwrite   = 1'b1;
        c.pcupdate  = 1'b1;
        c.alusrca   = 2'b00;
        c.alusrcb   = 2'b10;
        c.resultsrc = 2'b10;
        c.aluop     = ALUOP_ADD;
      end
      S_DECODE: begin
        // Branch/jal target is formed here from OldPC + immediate.
        c.alusrca = 2'b01;
        c.alusrcb = 2'b01;
        c.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        c.alusrca = 2'b10;
        c.alusrcb = 2'b01;
        c.aluop   = ALUOP_ADD;
      end
      S_MEMREAD: begin
        c.resultsrc = 2'b00;
        c.adrsrc    = 1'b1;
      end
      S_MEMWB: begin
        c.resultsrc = 2'b01;
        c.regwrite  = 1'b1;
        c.retire    = 1'b1;
      end
      S_MEMWRITE: begin
        c.resultsrc = 2'b00;
        c.adrsrc    = 1'b1;
        c.memwrite  = 1'b1;
        c.retire    = 1'b1;
      end
      S_EXECR: begin
        c.alusrca = 2'b10;
        c.alusrcb = 2'b00;
        c.aluop   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        c.alusrca = 2'b10;
        c.alusrcb = 2'b01;
        c.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.resultsrc = 2'b00;
        c.regwrite  = 1'b1;
        c.retire    = 1'b1;
      end
      S_JAL: begin
        c.alusrca   = 2'b01;
        c.alusrcb   = 2'b10;
        c.aluop     = ALUOP_ADD;
        c.resultsrc = 2'b00;
        c.pcupdate  = 1'b1;
        c.retire    = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca   = 2'b10;
        c.alusrcb   = 2'b00;
        c.aluop     = ALUOP_SUB;
        c.resultsrc = 2'b00;
        c.branch    = 1'b1;
        c.retire    = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt = next_state(state, op);
  end

  // The control word is registered together with the state, decoded from the
  // state being entered, so it is valid from the first cycle of that state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      ctl_q <= moore(S_FETCH);
    end else begin
      state <= nxt;
      ctl_q <= moore(nxt);
    end
  end

  // While reset is held the state may still be anywhere, so the selects are
  // forced to their FETCH values and every enable is gated off below.
  always_comb begin
    ctl = reset ? moore(S_FETCH) : ctl_q;
  end

  always_comb begin
    case (op)
      OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BR: supported = 1'b1;
      default:                                 supported = 1'b0;
    endcase
  end

  // The IR is loaded at the edge that enters DECODE, so this must look at op
  // combinationally rather than through the registered control word.
  always_comb begin
    dec_illegal = (state == S_DECODE) && !supported;
  end

  // beq takes on zero, bne on not-zero; other branch funct3 never take.
  always_comb begin
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   immsrc = 2'b01;
      OP_BR:   immsrc = 2'b10;
      OP_JAL:  immsrc = 2'b11;
      default: immsrc = 2'b00;
    endcase
  end

  always_comb begin
    alucontrol = 3'b000;
    case (ctl.aluop)
      ALUOP_ADD: alucontrol = 3'b000;
      ALUOP_SUB: alucontrol = 3'b001;
      ALUOP_FUNCT: begin
        case (funct3)
          // op[5] separates R-type from I-ALU; addi never subtracts.
          3'b000:  alucontrol = (op[5] && funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alucontrol = 3'b101;
          3'b110:  alucontrol = 3'b011;
          3'b111:  alucontrol = 3'b010;
          default: alucontrol = 3'b000;
        endcase
      end
      default: alucontrol = 3'b000;
    endcase
  end

  always_comb begin
    alusrca   = ctl.alusrca;
    alusrcb   = ctl.alusrcb;
    resultsrc = ctl.resultsrc;
    adrsrc    = ctl.adrsrc;
    irwrite   = !reset && ctl.irwrite;
    pcwrite   = !reset && (ctl.pcupdate || (ctl.branch && taken));
    regwrite  = !reset && ctl.regwrite;
    memwrite  = !reset && ctl.memwrite;
    retire    = !reset && (ctl.retire || dec_illegal);
    illegal   = !reset && dec_illegal;
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: per-instruction reference of expected outputs by cycle index.
// Latency: outputs are checked on the falling edge of every stimulated cycle.
// Backpressure: not applicable; stimulus runs open-loop on fixed cycle counts.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic [1:0] immsrc, alusrca, alusrcb, resultsrc;
  logic       adrsrc;
  logic [2:0] alucontrol;
  logic       irwrite, pcwrite, regwrite, memwrite, retire, illegal;

  mc_control_fsm dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .immsrc(immsrc), .alusrca(alusrca), .alusrcb(alusrcb), .resultsrc(resultsrc),
    .adrsrc(adrsrc), .alucontrol(alucontrol), .irwrite(irwrite), .pcwrite(pcwrite),
    .regwrite(regwrite), .memwrite(memwrite), .retire(retire), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Instruction classes.
  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_JAL = 4, C_BR = 5, C_ILL = 6;
  int cpi [7] = '{5, 4, 4, 4, 3, 3, 2};

  int          vectors = 0;
  int          miscompares = 0;
  logic [17:0] exp_v = '0;
  logic        exp_on = 1'b0;
  string       exp_tag = "";
  logic [17:0] act_v;

  assign act_v = {immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol,
                  irwrite, pcwrite, regwrite, memwrite, retire, illegal};

  always @(negedge clk) begin
    if (exp_on) begin
      vectors++;
      if (act_v !== exp_v) begin
        miscompares++;
        $display("FAIL %s: got %b required %b", exp_tag, act_v, exp_v);
      end
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] alu_fn(input logic [2:0] f3, input logic f7, input logic [6:0] o);
    if (f3 == 3'd0) return (o[5] && f7) ? 3'b001 : 3'b000;
    if (f3 == 3'd2) return 3'b101;
    if (f3 == 3'd6) return 3'b011;
    if (f3 == 3'd7) return 3'b010;
    return 3'b000;
  endfunction

  // Expected outputs for cycle k (0 = fetch) of an instruction of class cls.
  function automatic logic [17:0] model(input int cls, input int k, input logic [6:0] o,
                                        input logic [2:0] f3, input logic f7,
                                        input logic z, input logic rst);
    logic [1:0] a, b, r;
    logic       ad, irw, pcw, rw, mw, ret, ill;
    logic [2:0] alu;
    a = 2'b00; b = 2'b00; r = 2'b00; ad = 1'b0; alu = 3'b000;
    irw = 1'b0; pcw = 1'b0; rw = 1'b0; mw = 1'b0; ret = 1'b0; ill = 1'b0;
    if (rst) begin
      b = 2'b10; r = 2'b10;
    end else if (k == 0) begin
      b = 2'b10; r = 2'b10; irw = 1'b1; pcw = 1'b1;
    end else if (k == 1) begin
      a = 2'b01; b = 2'b01;
      if (cls == C_ILL) begin ret = 1'b1; ill = 1'b1; end
    end else begin
      ret = (k == cpi[cls] - 1);
      case (cls)
        C_LW, C_SW: begin
          if (k == 2) begin a = 2'b10; b = 2'b01; end
          else if (k == 3) begin
            ad = 1'b1;
            mw = (cls == C_SW);
          end else begin
            r = 2'b01; rw = 1'b1;
          end
        end
        C_R, C_I: begin
          if (k == 2) begin
            a = 2'b10; b = (cls == C_I) ? 2'b01 : 2'b00; alu = alu_fn(f3, f7, o);
          end else rw = 1'b1;
        end
        C_JAL: begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
        C_BR: begin
          a = 2'b10; alu = 3'b001;
          pcw = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z);
        end
        default: ;
      endcase
    end
    return {imm_of(o), a, b, r, ad, alu, irw, pcw, rw, mw, ret, ill};
  endfunction

  // Runs the first ncyc cycles of one instruction; zsel < 0 means random zero.
  task automatic run_instr(input int cls, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input int zsel, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk);
      #1;
      reset = 1'b0; op = o; funct3 = f3; funct7b5 = f7;
      zero = (zsel < 0) ? 1'($urandom % 2) : 1'(zsel);
      exp_v = model(cls, k, o, f3, f7, zero, 1'b0);
      exp_tag = $sformatf("cls%0d op%b f3%0d cyc%0d", cls, o, f3, k + 1);
      exp_on = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      reset = 1'b1;
      zero = 1'($urandom % 2);
      exp_v = model(C_LW, 0, op, funct3, funct7b5, zero, 1'b1);
      exp_tag = $sformatf("reset cyc%0d", k + 1);
      exp_on = 1'b1;
      @(negedge clk);
    end
  endtask

  function automatic logic [6:0] op_of(input int cls);
    logic [6:0] o;
    case (cls)
      C_LW:  o = 7'b0000011;
      C_SW:  o = 7'b0100011;
      C_R:   o = 7'b0110011;
      C_I:   o = 7'b0010011;
      C_JAL: o = 7'b1101111;
      C_BR:  o = 7'b1100011;
      default: begin
        o = 7'($urandom);
        while (o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
               o == 7'b0010011 || o == 7'b1101111 || o == 7'b1100011)
          o = 7'($urandom);
      end
    endcase
    return o;
  endfunction

  initial begin
    reset = 1'b1; op = 7'b0000011; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
    do_reset(2);

    // lw end to end
    run_instr(C_LW, op_of(C_LW), 3'd2, 1'b0, -1, 5);
    chk("lw_c5_regwrite", {3'b0, regwrite}, 4'h1);
    chk("lw_c5_resultsrc", {2'b0, resultsrc}, 4'h1);

    // reset held 3 cycles mid-MEMREAD
    run_instr(C_LW, op_of(C_LW), 3'd2, 1'b0, -1, 4);
    chk("memread_adrsrc", {3'b0, adrsrc}, 4'h1);
    do_reset(3);
    chk("reset_memwrite", {2'b0, memwrite, regwrite}, 4'h0);
    run_instr(C_R, op_of(C_R), 3'd0, 1'b1, -1, 1);
    chk("post_reset_fetch_en", {2'b0, irwrite, pcwrite}, 4'h3);
    chk("post_reset_alusrcb", {2'b0, alusrcb}, 4'h2);
    chk("post_reset_resultsrc", {2'b0, resultsrc}, 4'h2);
    do_reset(1);

    // R-type sub / add
    run_instr(C_R, op_of(C_R), 3'd0, 1'b1, -1, 3);
    chk("r_sub_alucontrol", {1'b0, alucontrol}, 4'h1);
    do_reset(1);
    run_instr(C_R, op_of(C_R), 3'd0, 1'b0, -1, 3);
    chk("r_add_alucontrol", {1'b0, alucontrol}, 4'h0);
    do_reset(1);
    run_instr(C_R, op_of(C_R), 3'd0, 1'b1, -1, 4);
    chk("r_c4_regwrite", {3'b0, regwrite}, 4'h1);

    // beq / bne with both zero values
    for (int f = 0; f < 2; f++) begin
      for (int z = 1; z >= 0; z--) begin
        run_instr(C_BR, op_of(C_BR), 3'(f), 1'b0, z, 3);
        chk($sformatf("br_f%0d_z%0d_pcwrite", f, z), {3'b0, pcwrite}, 4'((f == 0) ? z : 1 - z));
        chk("br_alucontrol", {1'b0, alucontrol}, 4'h1);
        chk("br_immsrc", {2'b0, immsrc}, 4'h2);
      end
    end

    // jal
    run_instr(C_JAL, op_of(C_JAL), 3'd5, 1'b1, -1, 3);
    chk("jal_immsrc", {2'b0, immsrc}, 4'h3);
    chk("jal_pc_reg", {2'b0, pcwrite, regwrite}, 4'h2);
    chk("jal_srcs", {alusrca, alusrcb}, 4'b0110);

    // illegal opcode then a normal instruction
    run_instr(C_ILL, 7'b1111111, 3'd0, 1'b0, -1, 2);
    chk("ill_flags", {2'b0, illegal, retire}, 4'h3);
    chk("ill_enables", {irwrite, pcwrite, regwrite, memwrite}, 4'h0);
    run_instr(C_I, op_of(C_I), 3'd7, 1'b0, -1, 4);

    // randomized instruction stream with occasional mid-instruction resets
    for (int n = 0; n < 400; n++) begin
      int          cls;
      logic [2:0]  f3;
      logic        f7;
      cls = int'($urandom_range(0, 6));
      f3  = 3'($urandom);
      f7  = 1'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        run_instr(cls, op_of(cls), f3, f7, -1, int'($urandom_range(1, cpi[cls])));
        do_reset(int'($urandom_range(1, 3)));
      end else begin
        run_instr(cls, op_of(cls), f3, f7, -1, cpi[cls]);
      end
    end

    exp_on = 1'b0;
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
